// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the 160x120 3-bit RAM used by the
// rectangle writer and the display reader.
package fb_pkg;

  localparam int H_RES  = 160;
  localparam int V_RES  = 120;
  localparam int PIX_W  = 3;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 24;

  typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} fb_state_e;

  localparam logic [PIX_W-1:0] BLACK   = 3'b000;
  localparam logic [PIX_W-1:0] BLUE    = 3'b001;
  localparam logic [PIX_W-1:0] GREEN   = 3'b010;
  localparam logic [PIX_W-1:0] CYAN    = 3'b011;
  localparam logic [PIX_W-1:0] RED     = 3'b100;
  localparam logic [PIX_W-1:0] MAGENTA = 3'b101;
  localparam logic [PIX_W-1:0] YELLOW  = 3'b110;
  localparam logic [PIX_W-1:0] WHITE   = 3'b111;

  // y*160 + x, with the multiply expressed as two shifts
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
    logic [ADDR_W-1:0] yw;
    yw = {{(ADDR_W-7){1'b0}}, y};
    return (yw << 7) + (yw << 5) + {{(ADDR_W-8){1'b0}}, x};
  endfunction

endpackage

// File: rtl/fb_rect_scan.sv
// Raster walker for one clipped rectangle: x/y/row_base counters that step
// on each accepted write and flag the final pixel.
module fb_rect_scan
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [7:0]        x0,
  input  logic [6:0]        y0,
  input  logic [7:0]        x_end,
  input  logic [6:0]        y_end,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [7:0]        x, x_start, x_stop;
  logic [6:0]        y, y_stop;
  logic [ADDR_W-1:0] row_base;
  logic              x_last, y_last;

  // ends are exclusive, so compare against x+1 / y+1 instead of end-1
  assign x_last = ({1'b0, x} + 9'd1) == {1'b0, x_stop};
  assign y_last = ({1'b0, y} + 8'd1) == {1'b0, y_stop};
  assign last   = x_last & y_last;
  assign addr   = row_base + {{(ADDR_W-8){1'b0}}, x};

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      x_start  <= '0;
      x_stop   <= '0;
      y_stop   <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= x0;
      y        <= y0;
      x_start  <= x0;
      x_stop   <= x_end;
      y_stop   <= y_end;
      row_base <= fb_addr(y0, 8'd0);
    end else if (advance) begin
      if (!x_last) begin
        x <= x + 8'd1;
      end else if (!y_last) begin
        x        <= x_start;
        y        <= y + 7'd1;
        row_base <= row_base + ADDR_W'(H_RES);
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: accepts one command, clips it to the framebuffer,
// issues one RAM write per pixel and reports per-command pixel/cycle counts.
//
// state | meaning
// IDLE  | ready for a command
// CLIP  | validate and clip latched command, load scan counters
// WRITE | one write per pixel, stalls on iWR_WAIT
// DONE  | one-cycle completion pulse, statistics published
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [7:0]        iCMD_X,
  input  logic [6:0]        iCMD_Y,
  input  logic [7:0]        iCMD_W,
  input  logic [6:0]        iCMD_H,
  input  logic [PIX_W-1:0]  iCMD_COLOR,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [PIX_W-1:0]  oWR_DATA,
  input  logic              iWR_WAIT,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic [ADDR_W-1:0] oPIXELS,
  output logic [CNT_W-1:0]  oCYCLES
);

  fb_state_e         state;
  logic [7:0]        cmd_x, cmd_w;
  logic [6:0]        cmd_y, cmd_h;
  logic [PIX_W-1:0]  cmd_color;
  logic [ADDR_W-1:0] pix_cnt;
  logic [CNT_W-1:0]  cyc_cnt, cyc_inc;
  logic [8:0]        x_sum;
  logic [7:0]        y_sum;
  logic [7:0]        x_end;
  logic [6:0]        y_end;
  logic              reject, accept, scan_load, scan_last;

  assign x_sum  = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum  = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign x_end  = (x_sum > 9'(H_RES)) ? 8'(H_RES) : x_sum[7:0];
  assign y_end  = (y_sum > 8'(V_RES)) ? 7'(V_RES) : y_sum[6:0];
  assign reject = (cmd_x >= 8'(H_RES)) | (cmd_y >= 7'(V_RES)) |
                  (cmd_w == 8'd0) | (cmd_h == 7'd0);

  assign accept    = oWR_EN & ~iWR_WAIT;
  assign scan_load = (state == CLIP) & ~reject;
  assign cyc_inc   = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CNT_W'(1);

  fb_rect_scan u_scan (
    .clk     (iCLK),
    .reset   (iRESET),
    .load    (scan_load),
    .advance (accept),
    .x0      (cmd_x),
    .y0      (cmd_y),
    .x_end   (x_end),
    .y_end   (y_end),
    .addr    (oWR_ADDR),
    .last    (scan_last)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= IDLE;
      oCMD_READY <= 1'b1;
      oWR_EN     <= 1'b0;
      oWR_DATA   <= '0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oERR       <= 1'b0;
      oPIXELS    <= '0;
      oCYCLES    <= '0;
      cmd_x      <= '0;
      cmd_y      <= '0;
      cmd_w      <= '0;
      cmd_h      <= '0;
      cmd_color  <= '0;
      pix_cnt    <= '0;
      cyc_cnt    <= '0;
    end else begin
      oDONE <= 1'b0;
      oERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (iCMD_VALID && oCMD_READY) begin
            cmd_x      <= iCMD_X;
            cmd_y      <= iCMD_Y;
            cmd_w      <= iCMD_W;
            cmd_h      <= iCMD_H;
            cmd_color  <= iCMD_COLOR;
            oCMD_READY <= 1'b0;
            oBUSY      <= 1'b1;
            pix_cnt    <= '0;
            cyc_cnt    <= CNT_W'(1);
            state      <= CLIP;
          end
        end
        CLIP: begin
          cyc_cnt <= cyc_inc;
          if (reject) begin
            oDONE   <= 1'b1;
            oERR    <= 1'b1;
            oPIXELS <= '0;
            oCYCLES <= cyc_inc;
            state   <= DONE;
          end else begin
            oWR_EN   <= 1'b1;
            oWR_DATA <= cmd_color;
            state    <= WRITE;
          end
        end
        WRITE: begin
          cyc_cnt <= cyc_inc;
          if (accept) begin
            pix_cnt <= pix_cnt + ADDR_W'(1);
            if (scan_last) begin
              oWR_EN  <= 1'b0;
              oDONE   <= 1'b1;
              oPIXELS <= pix_cnt + ADDR_W'(1);
              oCYCLES <= cyc_inc;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          oCMD_READY <= 1'b1;
          oBUSY      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: stimulus pushes expected writes and
// completions, a negedge monitor pops and compares them.
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [7:0]        cmd_x = '0, cmd_w = '0;
  logic [6:0]        cmd_y = '0, cmd_h = '0;
  logic [PIX_W-1:0]  cmd_color = '0;
  logic              wr_wait = 1'b0;
  logic              cmd_ready, wr_en, busy, done, err;
  logic [ADDR_W-1:0] wr_addr, pixels;
  logic [PIX_W-1:0]  wr_data;
  logic [CNT_W-1:0]  cycles;

  fb_rect_writer dut (
    .iCLK       (clk),
    .iRESET     (rst),
    .iCMD_VALID (cmd_valid),
    .oCMD_READY (cmd_ready),
    .iCMD_X     (cmd_x),
    .iCMD_Y     (cmd_y),
    .iCMD_W     (cmd_w),
    .iCMD_H     (cmd_h),
    .iCMD_COLOR (cmd_color),
    .oWR_EN     (wr_en),
    .oWR_ADDR   (wr_addr),
    .oWR_DATA   (wr_data),
    .iWR_WAIT   (wr_wait),
    .oBUSY      (busy),
    .oDONE      (done),
    .oERR       (err),
    .oPIXELS    (pixels),
    .oCYCLES    (cycles)
  );

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int err; int pix; int cyc; int at;} done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  wr_t   we;
  done_t de;
  int    errors = 0;
  int    checks = 0;
  int    cyc_no = 0;
  bit    prev_stall = 1'b0;
  int    prev_addr = 0;
  int    prev_data = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // monitor: compare every accepted write and every completion pulse
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_en", int'(wr_en), 1);
      chk("hold_addr", int'(wr_addr), prev_addr);
      chk("hold_data", int'(wr_data), prev_data);
    end
    prev_stall = wr_en && wr_wait;
    prev_addr  = int'(wr_addr);
    prev_data  = int'(wr_data);
    if (wr_en && !wr_wait) begin
      if (exp_wr.size() == 0) chk("unexpected_write_addr", int'(wr_addr), -1);
      else begin
        we = exp_wr.pop_front();
        chk("wr_addr", int'(wr_addr), we.addr);
        chk("wr_data", int'(wr_data), we.data);
      end
    end
    if (err) chk("err_with_done", int'(done), 1);
    if (done) begin
      if (exp_done.size() == 0) chk("unexpected_done_cycles", int'(cycles), -1);
      else begin
        de = exp_done.pop_front();
        chk("done_err", int'(err), de.err);
        chk("done_pixels", int'(pixels), de.pix);
        chk("done_cycles", int'(cycles), de.cyc);
        chk("done_time", cyc_no, de.at);
        chk("done_busy", int'(busy), 1);
        chk("done_ready", int'(cmd_ready), 0);
      end
    end
  end

  // Hold valid until the DUT is ready, then push the expected response.
  task automatic send(input int x, input int y, input int w, input int h,
                      input int c, input int waits);
    int n, acc, xe, ye, npix, cyc;
    bit rej;
    cmd_valid = 1'b1;
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 3'(c);
    n = 0;
    while (!cmd_ready && n < 30000) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) chk("ready_timeout", int'(cmd_ready), 1);
    @(posedge clk); #1;
    acc = cyc_no;
    cmd_valid = 1'b0;
    cmd_x = 8'($urandom); cmd_y = 7'($urandom); cmd_w = 8'($urandom);
    cmd_h = 7'($urandom); cmd_color = 3'($urandom);
    rej  = (x >= 160) || (y >= 120) || (w == 0) || (h == 0);
    xe   = (x + w > 160) ? 160 : x + w;
    ye   = (y + h > 120) ? 120 : y + h;
    npix = 0;
    if (!rej) begin
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++) begin
          exp_wr.push_back('{addr: yy * 160 + xx, data: c});
          npix++;
        end
    end
    cyc = rej ? 2 : npix + 2 + waits;
    exp_done.push_back('{err: int'(rej), pix: npix, cyc: cyc, at: acc + cyc - 1});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < 40000) begin
      @(posedge clk); #1; n++;
    end
    if (exp_done.size() != 0) chk("drain_timeout", exp_done.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  int'(cmd_ready), 1);
    chk({tag, "_wr_en"},  int'(wr_en), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_done"},   int'(done), 0);
    chk({tag, "_err"},    int'(err), 0);
    chk({tag, "_addr"},   int'(wr_addr), 0);
    chk({tag, "_data"},   int'(wr_data), 0);
    chk({tag, "_pixels"}, int'(pixels), 0);
    chk({tag, "_cycles"}, int'(cycles), 0);
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    send(0, 0, 4, 2, 4, 0);          drain();  // two rows with wrap
    send(158, 118, 10, 10, 2, 0);    drain();  // clipped to bottom-right 2x2
    send(160, 7, 5, 5, 1, 0);        drain();  // X off screen
    send(5, 5, 0, 3, 1, 0);          drain();  // zero width
    send(0, 120, 1, 1, 1, 0);        drain();  // Y off screen
    send(3, 3, 2, 0, 1, 0);          drain();  // zero height
    send(159, 119, 255, 127, 5, 0);  drain();  // single corner pixel, max sizes

    // stall the second pixel for three cycles
    send(10, 5, 3, 1, 3, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_wait = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    wr_wait = 1'b0;
    drain();

    // full screen, with a second command held valid while busy
    send(0, 0, 160, 120, 7, 0);
    send(20, 20, 2, 1, 2, 0);
    drain();

    // reset in the middle of a fill
    send(0, 10, 20, 3, 5, 0);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    exp_wr.delete();
    exp_done.delete();
    prev_stall = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    send(1, 1, 2, 2, 6, 0);
    drain();

    chk("wr_queue_empty", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
